data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Word-addressed data memory that acts as the responder end of a valid/ready load/store request interface issued by the processor datapath.
- Accepts one request at a time and waits a programmable number of cycles to model memory latency.
- Performs the read or write, then returns a response with its own valid/ready handshake.
- Flags misaligned or out-of-range accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; legal byte addresses are 0 .. 4*DEPTH_WORDS-4.
- LATENCY, 2, wait cycles between request acceptance and the memory operation; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, counter = 0.
  - All storage words cleared to 0.
  - req_ready = 1 once reset is released (it is a decode of IDLE).
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Any in-flight request is discarded; an un-performed write never reaches storage.
- FSM states are IDLE, WAIT and RESP. req_ready = (state == IDLE); resp_valid = (state == RESP). Both are decoded from the state register only, with no combinational path from inputs.
- IDLE:
  - On req_valid & req_ready at an edge, latch req_write, req_addr and req_wdata.
  - Load counter = LATENCY and go to WAIT.
- WAIT:
  - If counter != 0, decrement it.
  - If counter == 0, perform the operation at that edge and go to RESP.
  - Net timing: a request accepted at edge n shows resp_valid high after edge n+1+LATENCY. With LATENCY = 0 that is after edge n+1.
- Operation, decided at the WAIT->RESP edge:
  - err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH_WORDS).
  - If err: no storage change, resp_rdata = 0, resp_err = 1.
  - Else if write: mem[addr[31:2]] = wdata, resp_rdata = 0, resp_err = 0.
  - Else: resp_rdata = mem[addr[31:2]], resp_err = 0.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready at an edge; then go to IDLE.
  - resp_rdata and resp_err clear to 0 on leaving RESP.
- No request is accepted in WAIT or RESP. Minimum spacing between acceptances is LATENCY+3 cycles.
- A request input change while req_ready = 0 is ignored; requests are not queued.
- A read following a write to the same address returns the new data, because the operations are strictly sequential.
- Full address compare uses all 32 bits, so high addresses never wrap into the array.

Decomposition:
- Shared package data_mem_pkg holds:
  - the state encoding (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - the counter width constant LAT_W = 4;
  - the word size constant.
- One sub-module, resp_word_ram:
  - DEPTH_WORDS x 32 storage with asynchronous read, synchronous write enable and asynchronous active-low clear.
  - The FSM, counter and error check stay in data_mem_responder.

Test Plan:
- Store then load, LATENCY = 2, resp_ready held 1:
  - Store 0x0000_002A to addr 0x8 -> resp_valid 3 cycles after accept with resp_err = 0, resp_rdata = 0.
  - Then load addr 0x8 -> resp_rdata = 0x0000_002A.
- Misaligned access: store 0xDEAD_BEEF to addr 0x6 -> resp_err = 1, resp_rdata = 0; a subsequent load of addr 0x4 returns 0.
- Out of range (DEPTH_WORDS = 64): load addr 0x100 -> resp_err = 1; load addr 0xFC -> resp_err = 0, data 0.
- Response backpressure: hold resp_ready = 0 for 5 cycles during a load of a word holding 0x1234 -> resp_valid, resp_rdata and resp_err stay constant and req_ready stays 0; after one resp_ready pulse, req_ready = 1 the next cycle.
- Reset mid-operation: accept a store of 0x55 to addr 0x10 and assert rst low in WAIT -> outputs return to reset values immediately; a later load of 0x10 returns 0.
- LATENCY = 0 and back-to-back requests: req_valid held high with 3 loads queued by the bench -> each response appears 1 cycle after its accept, and accepts are exactly 3 cycles apart.

Source files
------------

// File: rtl/data_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_pkg                                                 |
// | Description : Shared state encoding, widths and address check for the     |
// |               data memory responder.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package data_mem_pkg;

  localparam int LAT_W  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // The full 30-bit word index is compared so high addresses never alias into the array.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/resp_word_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : resp_word_ram                                                |
// | Description : Word storage with asynchronous read, synchronous write and   |
// |               asynchronous active-low clear of every word.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module resp_word_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int WORD_W      = 32,
  parameter int AW          = 6
) (
  input  logic              clk_i,
  input  logic              clr_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Guards the read port when DEPTH_WORDS is not a power of two.
  assign rdata_o = (32'(addr_i) < 32'(DEPTH_WORDS)) ? mem_q[addr_i] : '0;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder                                           |
// | Description : Word-addressed data memory answering valid/ready load/store |
// |               requests after a programmable latency, flagging bad access. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2     // legal range 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  import data_mem_pkg::*;

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e             state_q;
  logic [LAT_W-1:0]   cnt_q;
  logic               write_q;
  logic [31:0]        addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [WORD_W-1:0]  rdata_q;
  logic               err_q;

  logic               acc_err;
  logic               op_fire;
  logic               ram_we;
  logic [WORD_W-1:0]  ram_rdata;

  assign acc_err = addr_err(addr_q, 32'(DEPTH_WORDS));
  assign op_fire = (state_q == WAIT) && (cnt_q == '0);
  assign ram_we  = op_fire && write_q && !acc_err;

  resp_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WORD_W      (WORD_W),
    .AW          (AW)
  ) u_ram (
    .clk_i   (clk),
    .clr_ni  (rst),
    .we_i    (ram_we),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= LAT_W'(LATENCY);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_W'(1);
          end else begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || write_q) ? '0 : ram_rdata;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode the state register only; no input-to-output path.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_data_mem_responder                                        |
// | Description : Scoreboard bench; instance 0 uses LATENCY=2, instance 1     |
// |               uses LATENCY=0 for back-to-back traffic.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit b2b_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : 0;
    exp_t exp_q[$];
    int   acc_q[$];

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT)) u_dut (
      .clk        (clk),
      .rst        (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );

    initial begin : mon
      bit   prev_v;
      int   last_acc;
      int   a;
      exp_t e;
      prev_v   = 1'b0;
      last_acc = -1;
      forever begin
        @(negedge clk);
        if (!rst_n[g]) begin
          acc_q.delete();
          prev_v   = 1'b0;
          last_acc = -1;
        end else begin
          if (!b2b_mode) last_acc = -1;
          if (req_valid[g] && req_ready[g]) begin
            if (b2b_mode && last_acc >= 0)
              check($sformatf("accept_gap_d%0d", g), 32'(cyc + 1 - last_acc), 32'd3);
            last_acc = cyc + 1;
            acc_q.push_back(cyc + 1);
          end
          if (resp_valid[g] && !prev_v) begin
            if (acc_q.size() == 0) begin
              check($sformatf("latency_noaccept_d%0d", g), 32'd0, 32'd1);
            end else begin
              a = acc_q.pop_front();
              check($sformatf("latency_d%0d", g), 32'(cyc - a), 32'(1 + LAT));
            end
          end
          prev_v = resp_valid[g];
          if (resp_valid[g] && resp_ready[g]) begin
            if (exp_q.size() == 0) begin
              check($sformatf("unexpected_resp_d%0d", g), 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check({e.name, "_rdata"}, resp_rdata[g], e.rdata);
              check({e.name, "_err"}, 32'(resp_err[g]), 32'(e.err));
            end
          end
        end
      end
    end
  end

  function automatic int exp_size(input int d);
    return (d == 0) ? g_dut[0].exp_q.size() : g_dut[1].exp_q.size();
  endfunction

  task automatic push_exp(input int d, input logic [31:0] rdata, input logic err, input string nm);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.name  = nm;
    if (d == 0) g_dut[0].exp_q.push_back(e);
    else        g_dut[1].exp_q.push_back(e);
  endtask

  // Wait at negedges for req_ready; the next rising edge accepts the request.
  task automatic wait_accept(input int d, input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[d] && t < 100);
    if (!req_ready[d]) check({nm, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit expect_resp, input logic [31:0] e_rdata, input logic e_err,
                      input string nm);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    if (expect_resp) push_exp(d, e_rdata, e_err, nm);
    wait_accept(d, nm);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_size(d) != 0 || resp_valid[d]) && t < 200);
    if (exp_size(d) != 0 || resp_valid[d])
      check($sformatf("drain_timeout_d%0d", d), 32'(exp_size(d)), 32'd0);
  endtask

  task automatic check_idle_outputs(input int d, input string nm);
    check({nm, "_req_ready"},  32'(req_ready[d]),  32'd1);
    check({nm, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
    check({nm, "_resp_rdata"}, resp_rdata[d],      32'd0);
    check({nm, "_resp_err"},   32'(resp_err[d]),   32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin : stim
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    int t;
    b2b_addr[0] = 32'h0000_0000; b2b_data[0] = 32'h1111_1111;
    b2b_addr[1] = 32'h0000_0004; b2b_data[1] = 32'h2222_2222;
    b2b_addr[2] = 32'h0000_00FC; b2b_data[2] = 32'h3333_3333;

    for (int d = 0; d < 2; d++) begin
      rst_n[d]      = 1'b0;
      req_valid[d]  = 1'b0;
      req_write[d]  = 1'b0;
      req_addr[d]   = '0;
      req_wdata[d]  = '0;
      resp_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #2;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    check_idle_outputs(0, "reset_d0");
    check_idle_outputs(1, "reset_d1");

    // Store then load with LATENCY = 2.
    send(0, 1'b1, 32'h0000_0008, 32'h0000_002A, 1'b1, 32'h0,         1'b0, "st_8");
    send(0, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h0000_002A, 1'b0, "ld_8");
    // Misaligned store must not touch word 1.
    send(0, 1'b1, 32'h0000_0006, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b1, "st_6_misal");
    send(0, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h0,         1'b0, "ld_4");
    // Range boundaries and no aliasing of high addresses.
    send(0, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0,         1'b1, "ld_100_oor");
    send(0, 1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'h0,         1'b0, "ld_fc");
    send(0, 1'b1, 32'h8000_0008, 32'h0000_0055, 1'b1, 32'h0,         1'b1, "st_hi_oor");
    send(0, 1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h0000_002A, 1'b0, "ld_8_again");
    send(0, 1'b1, 32'h0000_0020, 32'h0000_1234, 1'b1, 32'h0,         1'b0, "st_20");
    drain(0);

    // Response backpressure.
    resp_ready[0] = 1'b0;
    send(0, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h0000_1234, 1'b0, "ld_20_bp");
    t = 0;
    while (!resp_valid[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", 32'(resp_valid[0]), 32'd1);
      check("bp_resp_rdata", resp_rdata[0],      32'h0000_1234);
      check("bp_resp_err",   32'(resp_err[0]),   32'd0);
      check("bp_req_ready",  32'(req_ready[0]),  32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready[0] = 1'b1;
    @(posedge clk);
    #1 resp_ready[0] = 1'b0;
    @(negedge clk);
    check_idle_outputs(0, "after_bp");
    resp_ready[0] = 1'b1;

    // Reset while the store sits in WAIT.
    send(0, 1'b1, 32'h0000_0010, 32'h0000_0055, 1'b0, 32'h0, 1'b0, "st_10_rst");
    @(negedge clk);
    #2 rst_n[0] = 1'b0;
    #1;
    check_idle_outputs(0, "mid_reset");
    @(negedge clk);
    #2 rst_n[0] = 1'b1;
    send(0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h0, 1'b0, "ld_10_after_rst");
    send(0, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 32'h0, 1'b0, "ld_8_cleared");
    drain(0);

    // LATENCY = 0: preload, then three loads with req_valid held high.
    for (int k = 0; k < 3; k++)
      send(1, 1'b1, b2b_addr[k], b2b_data[k], 1'b1, 32'h0, 1'b0, $sformatf("b_st%0d", k));
    drain(1);
    @(posedge clk);
    #1;
    b2b_mode     = 1'b1;
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_addr[1]  = b2b_addr[0];
    push_exp(1, b2b_data[0], 1'b0, "b_ld0");
    for (int k = 0; k < 3; k++) begin
      wait_accept(1, $sformatf("b_ld%0d", k));
      if (k < 2) begin
        req_addr[1] = b2b_addr[k+1];
        push_exp(1, b2b_data[k+1], 1'b0, $sformatf("b_ld%0d", k + 1));
      end else begin
        req_valid[1] = 1'b0;
      end
    end
    drain(1);
    b2b_mode = 1'b0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
